// File: rtl/uart_pkg.sv
// Shared types and helpers for the periodic UART transmitter.
// Frame states, data width and baud terminal-count helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int calc_mcnt_baud(input int clk_freq, input int baud);
    return clk_freq / baud - 1;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-frame UART serializer: start, LSB-first data, optional even parity, stop.
// UART_PARITY_EN adds the parity bit; a start request is ignored while a frame is in flight.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int MCNT_BAUD = 433
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 busy,
  output logic                 tx
);

  localparam int BW = (MCNT_BAUD > 0) ? $clog2(MCNT_BAUD + 1) : 1;

  state_t                 state;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   tx_byte;
  logic                   bit_end;

  assign bit_end = (baud_cnt == BW'(MCNT_BAUD));
  assign busy    = (state != IDLE);

  // tx is updated on the same edge as the state it belongs to, so it is always a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_byte  <= '0;
      tx       <= 1'b1;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      if (start) begin
        state   <= START;
        tx_byte <= tx_data;
        tx      <= 1'b0;
      end
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + BW'(1);
    end else begin
      baud_cnt <= '0;
      case (state)
        START: begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= tx_byte[0];
        end
        DATA: begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state <= PARITY;
            tx    <= ^tx_byte;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= tx_byte[bit_idx + 3'd1];
          end
        end
        PARITY: begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_periodic_byte_tx.sv
// Sends Data as one UART frame every MCNT_DLY+1 clocks and toggles LED per trigger.
// UART_PARITY_EN selects 8E1 framing; triggers landing mid-frame only toggle LED.
module uart_periodic_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int MCNT_BAUD = calc_mcnt_baud(CLK_FREQ, BAUD),
  parameter int MCNT_DLY  = 50_000_000 - 1
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic [DATA_BITS-1:0] Data,
  output logic                 uart_tx,
  output logic                 LED
);

  localparam int DW = (MCNT_DLY > 0) ? $clog2(MCNT_DLY + 1) : 1;

  logic [DW-1:0] dly_cnt;
  logic          trigger;
  logic          busy;
  logic          start;

  assign trigger = (dly_cnt == DW'(MCNT_DLY));

  // The interval counter never stalls, so the send cadence is independent of frame length.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      dly_cnt <= '0;
      LED     <= 1'b0;
    end else begin
      dly_cnt <= trigger ? '0 : dly_cnt + DW'(1);
      if (trigger) LED <= ~LED;
    end
  end

  assign start = trigger & ~busy;

  uart_tx_core #(
    .MCNT_BAUD (MCNT_BAUD)
  ) u_core (
    .clk     (CLK),
    .rst_n   (Reset_n),
    .start   (start),
    .tx_data (Data),
    .busy    (busy),
    .tx      (uart_tx)
  );

endmodule

// File: tb/tb_uart_periodic_byte_tx.sv
// Bench for uart_periodic_byte_tx with short baud/interval counts and a frame-level line model.
module tb_uart_periodic_byte_tx;

  localparam int MB  = 7;
  localparam int MD  = 26;
  localparam int P   = MB + 1;
  localparam int IV  = MD + 1;
`ifdef UART_PARITY_EN
  localparam int FL  = 11;
  localparam bit PAR = 1'b1;
  localparam logic [10:0] LIT55 = 11'h4AA;
`else
  localparam int FL  = 10;
  localparam bit PAR = 1'b0;
  localparam logic [10:0] LIT55 = 11'h2AA;
`endif

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b1;
  logic [7:0] Data = 8'h55;
  logic       uart_tx;
  logic       LED;

  int checks = 0;
  int errors = 0;

  uart_periodic_byte_tx #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (115_200),
    .MCNT_BAUD (MB),
    .MCNT_DLY  (MD)
  ) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .Data    (Data),
    .uart_tx (uart_tx),
    .LED     (LED)
  );

  always #5 CLK = ~CLK;

  // Model: k = edges since reset release; a trigger every IV edges starts a frame
  // only if the previous one has fully finished (stop bit plus the return to idle).
  int         m_k = 0;
  int         m_last = 0;
  bit         m_active = 1'b0;
  logic       m_led = 1'b0;
  logic [7:0] m_byte = 8'h00;

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      m_k      = 0;
      m_active = 1'b0;
      m_led    = 1'b0;
    end else begin
      m_k = m_k + 1;
      if (m_k % IV == 0) begin
        m_led = ~m_led;
        if (!m_active || (m_k - m_last) >= FL * P + 1) begin
          m_active = 1'b1;
          m_last   = m_k;
          m_byte   = Data;
        end
      end
    end
  end

  function automatic int model_bit();
    int off;
    if (!m_active) return -1;
    off = m_k - m_last;
    if (off >= FL * P) return -1;
    return off / P;
  endfunction

  function automatic logic model_tx();
    int b;
    b = model_bit();
    if (b < 0) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    if (PAR && b == 9) return ^m_byte;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    check("uart_tx", uart_tx, model_tx());
    check("LED", LED, m_led);
  end

  task automatic first_fall(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      n++;
      if (uart_tx == 1'b0) break;
    end
    checks++;
    if (n != IV) begin
      errors++;
      $display("FAIL %s: start bit after %0d edges, want %0d", name, n, IV);
    end
  endtask

  initial begin
    logic [10:0] got;
    bit found;
    got = '0;
    #1 Reset_n = 1'b0;
    #200;
    check("reset_tx", uart_tx, 1'b1);
    check("reset_led", LED, 1'b0);
    @(negedge CLK);
    Reset_n = 1'b1;

    first_fall("first_start");
    check("led_first", LED, 1'b1);
    for (int i = 0; i < FL; i++) begin
      got[i] = uart_tx;
      repeat (P) @(posedge CLK);
      #1;
    end
    checks++;
    if (got !== LIT55) begin
      errors++;
      $display("FAIL frame55: got %h want %h", got, LIT55);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 15) == 0) Data = 8'($urandom);
    end

    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (model_bit() == 4) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL find_d3: no frame reached d3 within budget");
    end
    #2 Reset_n = 1'b0;
    #1;
    check("abort_tx", uart_tx, 1'b1);
    check("abort_led", LED, 1'b0);
    Data = 8'h07;
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;
    first_fall("restart");
    repeat (300) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
